id_hazard_scoreboard: RTL

Hazard controller that drives the flush input of the ID/EX pipeline register and the freeze input of the PC and IF/ID register. It tracks the destination register, load flag and flag-update bit of every instruction it lets through ID. It keeps this in an internal two-slot scoreboard (EXE, MEM) instead of reading back the pipeline registers. It detects RAW, load-use and flag hazards against the instruction currently in ID, and sequences branch flushes.

---
 rtl/id_hazard_scoreboard_pkg.sv | 25 ++
 rtl/id_hazard_scoreboard_if.sv | 54 +++++
 rtl/id_hazard_scoreboard_hazard_cmp.sv | 24 ++
 rtl/id_hazard_scoreboard.sv | 103 ++++++++++
 4 files changed

// File: rtl/id_hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// id_hazard_scoreboard_pkg
// Shared constants for the ID-stage hazard scoreboard.
//   - REG_ADDR_W_DEF / CNT_W_DEF : default register-address and counter widths
//   - SB_* : bit offsets of the fields inside one scoreboard slot. The
//            destination field is last so the other offsets do not move when
//            the register-address width changes.
//   - slot_w() : total slot width for a given register-address width
// -----------------------------------------------------------------------------
package id_hazard_scoreboard_pkg;

  localparam int REG_ADDR_W_DEF = 4;
  localparam int CNT_W_DEF      = 16;

  // Slot layout: {dst, s_upd, mem_read, wb}
  localparam int SB_WB    = 0;
  localparam int SB_MEMRD = 1;
  localparam int SB_SUPD  = 2;
  localparam int SB_DST   = 3;

  function automatic int slot_w(input int reg_addr_w);
    return reg_addr_w + SB_DST;
  endfunction

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// id_hazard_scoreboard_if
// Bundles the ID-stage instruction descriptor, the branch/config inputs and
// the pipeline control outputs of the hazard scoreboard.
//   master : driven by the pipeline (decode stage / EXE branch unit)
//   slave  : the hazard scoreboard itself
// Signals:
//   fwd_en, branch_taken                      configuration / EXE branch
//   id_src1, id_src2, id_use_src1, id_two_src sources read by the ID instr
//   id_cond_flags                             ID instr reads NZCV
//   id_wb_en, id_dst, id_mem_read, id_s_update what the ID instr produces
//   freeze, idex_flush, ifid_flush            pipeline control
//   stall_cnt                                 saturating freeze-cycle count
//   dbg_exe_slot, dbg_mem_slot                scoreboard contents (observation)
// -----------------------------------------------------------------------------
interface id_hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);

  localparam int SLOT_W = REG_ADDR_W + 3;

  logic                  fwd_en;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_use_src1;
  logic                  id_two_src;
  logic                  id_cond_flags;
  logic                  id_wb_en;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_mem_read;
  logic                  id_s_update;
  logic                  branch_taken;

  logic                  freeze;
  logic                  idex_flush;
  logic                  ifid_flush;
  logic [CNT_W-1:0]      stall_cnt;
  logic [SLOT_W-1:0]     dbg_exe_slot;
  logic [SLOT_W-1:0]     dbg_mem_slot;

  modport master (
    output fwd_en, id_src1, id_src2, id_use_src1, id_two_src, id_cond_flags,
           id_wb_en, id_dst, id_mem_read, id_s_update, branch_taken,
    input  freeze, idex_flush, ifid_flush, stall_cnt, dbg_exe_slot, dbg_mem_slot
  );

  modport slave (
    input  fwd_en, id_src1, id_src2, id_use_src1, id_two_src, id_cond_flags,
           id_wb_en, id_dst, id_mem_read, id_s_update, branch_taken,
    output freeze, idex_flush, ifid_flush, stall_cnt, dbg_exe_slot, dbg_mem_slot
  );

endinterface

// File: rtl/id_hazard_scoreboard_hazard_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp
// Compares one scoreboard slot against the two source registers of the
// instruction in ID. A slot that does not write back never matches.
//   wb_i, dst_i     : slot write-enable and destination
//   src1_i, src2_i  : ID source registers
//   match1_o/2_o    : slot writes the register named by src1/src2
// -----------------------------------------------------------------------------
module hazard_cmp #(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  wb_i,
  input  logic [REG_ADDR_W-1:0] dst_i,
  input  logic [REG_ADDR_W-1:0] src1_i,
  input  logic [REG_ADDR_W-1:0] src2_i,
  output logic                  match1_o,
  output logic                  match2_o
);

  // Full-width equality: R15 is compared like any other register.
  assign match1_o = wb_i & (dst_i == src1_i);
  assign match2_o = wb_i & (dst_i == src2_i);

endmodule

// File: rtl/id_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// id_hazard_scoreboard
// Controls the ID/EX flush and the PC / IF/ID freeze. Tracks what each
// instruction that left ID will write, in a two-slot shift register
// (EXE, MEM), and detects RAW, load-use and flag hazards against the
// instruction currently in ID. A taken branch in EXE has priority: the ID
// instruction is discarded instead of frozen.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : id_hazard_scoreboard_if.slave (ID descriptor in, controls out)
// All control outputs are combinational from the slots and the inputs.
// -----------------------------------------------------------------------------
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  id_hazard_scoreboard_if.slave  bus
);

  localparam int SLOT_W = REG_ADDR_W + SB_DST;

  logic [SLOT_W-1:0] exe_q, exe_d;
  logic [SLOT_W-1:0] mem_q, mem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] id_slot;

  logic m1x, m2x, m1m, m2m;
  logic raw_nofwd, raw_fwd, flag_hz, hz;
  logic freeze, idex_flush;

  // Descriptor of the instruction in ID, in slot layout.
  always_comb begin
    id_slot                         = '0;
    id_slot[SB_WB]                  = bus.id_wb_en;
    id_slot[SB_MEMRD]               = bus.id_mem_read;
    id_slot[SB_SUPD]                = bus.id_s_update;
    id_slot[SB_DST +: REG_ADDR_W]   = bus.id_dst;
  end

  hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_exe (
    .wb_i     (exe_q[SB_WB]),
    .dst_i    (exe_q[SB_DST +: REG_ADDR_W]),
    .src1_i   (bus.id_src1),
    .src2_i   (bus.id_src2),
    .match1_o (m1x),
    .match2_o (m2x)
  );

  hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_mem (
    .wb_i     (mem_q[SB_WB]),
    .dst_i    (mem_q[SB_DST +: REG_ADDR_W]),
    .src1_i   (bus.id_src1),
    .src2_i   (bus.id_src2),
    .match1_o (m1m),
    .match2_o (m2m)
  );

  // WB is never a source: the register file writes in the first half of WB.
  always_comb begin
    raw_nofwd  = (bus.id_use_src1 & (m1x | m1m)) | (bus.id_two_src & (m2x | m2m));
    // With forwarding only a load still in EXE cannot be bypassed in time.
    raw_fwd    = exe_q[SB_MEMRD] & ((bus.id_use_src1 & m1x) | (bus.id_two_src & m2x));
    // Flags are written at the end of EXE; no bypass path exists for them.
    flag_hz    = bus.id_cond_flags & exe_q[SB_SUPD];
    hz         = (bus.fwd_en ? raw_fwd : raw_nofwd) | flag_hz;
    freeze     = hz & ~bus.branch_taken;
    idex_flush = hz | bus.branch_taken;
  end

  always_comb begin
    exe_d = idex_flush ? '0 : id_slot;
    mem_d = exe_q;
    cnt_d = cnt_q;
    if (freeze && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.freeze       = freeze;
  assign bus.idex_flush   = idex_flush;
  assign bus.ifid_flush   = bus.branch_taken;
  assign bus.stall_cnt    = cnt_q;
  assign bus.dbg_exe_slot = exe_q;
  assign bus.dbg_mem_slot = mem_q;

endmodule
